// File: rtl/interrupt_sequence_controller.sv
// Priority resolver and two-pulse INTA sequencer for an 8259A-style PIC in 8086 mode.
// Owns the ISR, raises INT, freezes/clears the request latch and drives the vector bus.
module interrupt_sequence_controller #(
  parameter int unsigned IR_COUNT = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [IR_COUNT-1:0] interrupt_request_register,
  input  logic [IR_COUNT-1:0] interrupt_mask,
  input  logic [4:0]          interrupt_vector_base,
  input  logic                auto_eoi_config,
  input  logic                end_of_interrupt,
  input  logic                interrupt_acknowledge_n,
  output logic                freeze,
  output logic [IR_COUNT-1:0] clear_interrupt_request,
  output logic                interrupt_to_cpu,
  output logic [IR_COUNT-1:0] in_service_register,
  output logic [7:0]          interrupt_vector_out,
  output logic                interrupt_vector_out_enable
);

  typedef enum logic [1:0] {StIdle, StAck1, StWait2, StAck2} state_e;

  // Index of the lowest set bit; 8 means no bit set, which also orders below every line.
  function automatic logic [3:0] lowest_set(input logic [IR_COUNT-1:0] v);
    logic [3:0] idx;
    idx = 4'd8;
    for (int i = IR_COUNT - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  state_e              r_state, w_state_next;
  logic                r_inta;
  logic [IR_COUNT-1:0] r_isr, w_isr_next;
  logic [2:0]          r_index, w_index_next;
  logic                r_spurious, w_spurious_next;
  logic                r_freeze, w_freeze_next;
  logic [IR_COUNT-1:0] r_clear, w_clear_next;
  logic                r_int, w_int_next;
  logic [7:0]          r_vector, w_vector_next;
  logic                r_vector_en, w_vector_en_next;

  logic [3:0]          w_req_low;
  logic [3:0]          w_isr_low;
  logic [3:0]          w_isr_eoi_low;
  logic [IR_COUNT-1:0] w_isr_eoi;
  logic                w_int_pending;
  logic                w_ack_pending;
  logic                w_fall;
  logic                w_rise;

  assign w_fall = r_inta & ~interrupt_acknowledge_n;
  assign w_rise = ~r_inta & interrupt_acknowledge_n;

  always_comb begin
    w_req_low = lowest_set(interrupt_request_register & ~interrupt_mask);
    w_isr_low = lowest_set(r_isr);
    w_isr_eoi = r_isr;
    if (end_of_interrupt && !w_isr_low[3]) begin
      w_isr_eoi[w_isr_low[2:0]] = 1'b0;
    end
    w_isr_eoi_low = lowest_set(w_isr_eoi);
    w_int_pending = (w_req_low < w_isr_low);
    // The acknowledge decision sees the ISR after a coincident EOI has been applied.
    w_ack_pending = (w_req_low < w_isr_eoi_low);
  end

  always_comb begin
    w_state_next     = r_state;
    w_isr_next       = w_isr_eoi;
    w_index_next     = r_index;
    w_spurious_next  = r_spurious;
    w_freeze_next    = r_freeze;
    w_clear_next     = '0;
    w_int_next       = 1'b0;
    w_vector_next    = r_vector;
    w_vector_en_next = r_vector_en;
    unique case (r_state)
      StIdle: begin
        w_int_next = w_int_pending;
        if (w_fall) begin
          w_int_next      = 1'b0;
          w_freeze_next   = 1'b1;
          w_spurious_next = ~w_ack_pending;
          w_state_next    = StAck1;
          if (w_ack_pending) begin
            w_index_next                  = w_req_low[2:0];
            w_isr_next[w_req_low[2:0]]    = 1'b1;
            w_clear_next[w_req_low[2:0]]  = 1'b1;
          end else begin
            w_index_next = 3'd7;
          end
        end
      end
      StAck1: begin
        if (w_rise) w_state_next = StWait2;
      end
      StWait2: begin
        if (w_fall) begin
          w_vector_next    = {interrupt_vector_base, r_index};
          w_vector_en_next = 1'b1;
          w_state_next     = StAck2;
        end
      end
      StAck2: begin
        if (w_rise) begin
          w_vector_next    = '0;
          w_vector_en_next = 1'b0;
          w_freeze_next    = 1'b0;
          w_state_next     = StIdle;
          if (auto_eoi_config && !r_spurious) begin
            w_isr_next[r_index] = 1'b0;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_inta      <= 1'b1;
      r_isr       <= '0;
      r_index     <= '0;
      r_spurious  <= 1'b0;
      r_freeze    <= 1'b0;
      r_clear     <= '0;
      r_int       <= 1'b0;
      r_vector    <= '0;
      r_vector_en <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_inta      <= interrupt_acknowledge_n;
      r_isr       <= w_isr_next;
      r_index     <= w_index_next;
      r_spurious  <= w_spurious_next;
      r_freeze    <= w_freeze_next;
      r_clear     <= w_clear_next;
      r_int       <= w_int_next;
      r_vector    <= w_vector_next;
      r_vector_en <= w_vector_en_next;
    end
  end

  assign freeze                      = r_freeze;
  assign clear_interrupt_request     = r_clear;
  assign interrupt_to_cpu            = r_int;
  assign in_service_register         = r_isr;
  assign interrupt_vector_out        = r_vector;
  assign interrupt_vector_out_enable = r_vector_en;

endmodule
